// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - arbitrates instruction and data L1 misses onto one L2 port
// Optional round-robin tie-breaking: CACHE_ARB_ROUND_ROBIN_EN
module cache_arbiter #(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [31:0]       i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              l2_read,
  output logic              l2_write,
  output logic [31:0]       l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic              l2_resp,
  input  logic [LINE_W-1:0] l2_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t            state;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] rdata_q;
  logic              i_req;
  logic              d_req;
  logic              pick_d;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  logic last_d_q;
`endif

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign pick_d = d_req && (!i_req || !last_d_q);
`else
  assign pick_d = d_req;
`endif

  // L2 side sees only captured request state, never live L1 inputs
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;
  assign i_rdata    = rdata_q;
  assign d_rdata    = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      l2_read  <= 1'b0;
      l2_write <= 1'b0;
      i_resp   <= 1'b0;
      d_resp   <= 1'b0;
      busy     <= 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            busy <= 1'b1;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            last_d_q <= pick_d;
`endif
            if (pick_d) begin
              // a simultaneous read and write is treated as a write
              addr_q   <= d_address;
              wdata_q  <= d_wdata;
              l2_write <= d_write;
              l2_read  <= ~d_write;
              state    <= SERVE_D;
            end else begin
              addr_q   <= i_address;
              wdata_q  <= '0;
              l2_write <= 1'b0;
              l2_read  <= 1'b1;
              state    <= SERVE_I;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) begin
            rdata_q  <= l2_rdata;
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            i_resp   <= (state == SERVE_I);
            d_resp   <= (state == SERVE_D);
            state    <= DONE;
          end
        end
        DONE: begin
          // no grant here, so a requester still holding its op is not served twice
          i_resp <= 1'b0;
          d_resp <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - directed self-checking bench for cache_arbiter
module tb_cache_arbiter;

  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [31:0]   i_address;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [31:0]   d_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          l2_read;
  logic          l2_write;
  logic [31:0]   l2_address;
  logic [LW-1:0] l2_wdata;
  logic          l2_resp;
  logic [LW-1:0] l2_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int i_cnt = 0;
  int d_cnt = 0;
  int txn   = 0;
  int excl  = 0;
  int mark_i;
  int mark_d;
  int mark_t;
  logic prev_op = 1'b0;

  localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] LINE_3C = {32{8'h3C}};
  localparam logic [LW-1:0] LINE_B1 = {32{8'hB1}};
  localparam logic [LW-1:0] LINE_C7 = {32{8'hC7}};
  localparam logic [LW-1:0] LINE_5E = {32{8'h5E}};

  cache_arbiter #(.LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_resp(l2_resp), .l2_rdata(l2_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_resp) i_cnt++;
    if (d_resp) d_cnt++;
    if ((l2_read | l2_write) && !prev_op) txn++;
    prev_op = l2_read | l2_write;
    if ((i_resp && d_resp) || (l2_read && l2_write)) excl++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic serve(input int lat, input logic [LW-1:0] line);
    repeat (lat - 1) tick;
    chk("op_held", LW'(l2_read | l2_write), LW'(1));
    l2_rdata = line;
    l2_resp  = 1'b1;
    tick;
    l2_resp  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; l2_resp = 0; l2_rdata = '0;
    tick;
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_l2ctl", LW'({l2_read, l2_write, i_resp, d_resp}), LW'(0));
    chk("rst_addr", LW'(l2_address), LW'(0));
    chk("rst_rdata", i_rdata, '0);
    rst = 1'b0;
    l2_resp = 1'b1;
    tick;
    chk("idle_l2resp_ignored", LW'({busy, i_resp, d_resp}), LW'(0));
    l2_resp = 1'b0;

    // single I read, L2 answers 5 cycles after the op appears, read held through DONE
    mark_i = i_cnt; mark_d = d_cnt; mark_t = txn;
    i_read = 1; i_address = 32'h0000_0040;
    tick;
    chk("i_l2_read", LW'({l2_read, l2_write}), LW'(2'b10));
    chk("i_l2_addr", LW'(l2_address), LW'(32'h40));
    chk("i_busy", LW'(busy), LW'(1));
    serve(5, LINE_A5);
    chk("i_resp", LW'({i_resp, d_resp}), LW'(2'b10));
    chk("i_rdata", i_rdata, LINE_A5);
    chk("i_done_l2_low", LW'({l2_read, l2_write}), LW'(0));
    tick;
    i_read = 0;
    chk("i_resp_one_cycle", LW'({i_resp, busy}), LW'(0));
    repeat (3) tick;
    chk("i_one_txn", LW'(txn - mark_t), LW'(1));
    chk("i_one_resp", LW'(i_cnt - mark_i), LW'(1));
    chk("i_no_dresp", LW'(d_cnt - mark_d), LW'(0));

    // D write
    mark_d = d_cnt;
    d_write = 1; d_address = 32'h1000_0020; d_wdata = LINE_3C;
    tick;
    chk("dw_l2ctl", LW'({l2_read, l2_write}), LW'(2'b01));
    chk("dw_addr", LW'(l2_address), LW'(32'h1000_0020));
    chk("dw_wdata", l2_wdata, LINE_3C);
    serve(3, LINE_5E);
    chk("dw_resp", LW'({i_resp, d_resp, l2_write}), LW'(3'b010));
    tick;
    d_write = 0;
    tick;
    chk("dw_one_resp", LW'(d_cnt - mark_d), LW'(1));

    // tie from reset
    rst = 1; tick; rst = 0;
    mark_i = i_cnt; mark_d = d_cnt;
    i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
    tick;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    chk("tie1_first_i", LW'(l2_address), LW'(32'h100));
    serve(1, LINE_B1);
    chk("tie1_iresp", LW'({i_resp, d_resp}), LW'(2'b10));
    tick;
    tick;
    chk("tie2_first_d", LW'(l2_address), LW'(32'h200));
    serve(1, LINE_C7);
    chk("tie2_dresp", LW'({i_resp, d_resp}), LW'(2'b01));
    chk("tie2_drdata", d_rdata, LINE_C7);
    tick;
    i_read = 0; d_read = 0;
`else
    chk("tie_first_d", LW'(l2_address), LW'(32'h200));
    serve(1, LINE_B1);
    chk("tie_dresp", LW'({i_resp, d_resp}), LW'(2'b01));
    chk("tie_drdata", d_rdata, LINE_B1);
    tick;
    d_read = 0;
    tick;
    chk("tie_then_i", LW'(l2_address), LW'(32'h100));
    serve(1, LINE_C7);
    chk("tie_iresp", LW'({i_resp, d_resp}), LW'(2'b10));
    chk("tie_irdata", i_rdata, LINE_C7);
    tick;
    i_read = 0;
`endif
    tick;
    chk("tie_idle", LW'({busy, l2_read}), LW'(0));
    chk("tie_resp_counts", LW'({i_cnt - mark_i, d_cnt - mark_d}), LW'({32'd1, 32'd1}));

    // D address changes mid-transaction
    d_read = 1; d_address = 32'h200;
    tick;
    d_address = 32'h300;
    chk("dchg_addr0", LW'(l2_address), LW'(32'h200));
    tick;
    chk("dchg_addr1", LW'(l2_address), LW'(32'h200));
    tick;
    chk("dchg_addr2", LW'(l2_address), LW'(32'h200));
    serve(1, LINE_5E);
    chk("dchg_resp", LW'(d_resp), LW'(1));
    tick;
    d_read = 0;
    tick;

    // reset two cycles into SERVE_I, read held across it
    mark_i = i_cnt;
    i_read = 1; i_address = 32'h40;
    tick;
    tick;
    tick;
    rst = 1;
    #1;
    chk("rst_mid_drop", LW'({l2_read, busy, i_resp}), LW'(0));
    tick;
    rst = 0;
    chk("rst_mid_noresp", LW'(i_cnt - mark_i), LW'(0));
    tick;
    chk("post_rst_read", LW'({l2_read, busy}), LW'(2'b11));
    serve(2, LINE_A5);
    chk("post_rst_resp", LW'({i_resp, d_resp}), LW'(2'b10));
    chk("post_rst_rdata", i_rdata, LINE_A5);
    tick;
    i_read = 0;
    tick;
    chk("post_rst_one_resp", LW'(i_cnt - mark_i), LW'(1));
    chk("exclusive", LW'(excl), LW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning the cache line width in bits on every data port.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have inputs i_read (1), i_address (32) from the instruction L1 miss port.
REQ-005 The block SHALL have outputs i_resp (1), i_rdata (LINE_W) to the instruction L1.
REQ-006 The block SHALL have inputs d_read (1), d_write (1), d_address (32), d_wdata (LINE_W) from the data L1 miss/writeback port.
REQ-007 The block SHALL have outputs d_resp (1), d_rdata (LINE_W) to the data L1.
REQ-008 The block SHALL have outputs l2_read (1), l2_write (1), l2_address (32), l2_wdata (LINE_W) to the L2 cache.
REQ-009 The block SHALL have inputs l2_resp (1), l2_rdata (LINE_W) from the L2 cache.
REQ-010 The block SHALL have output busy (1), high in any state other than IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, SERVE_I, SERVE_D and DONE.
REQ-012 In IDLE with exactly one requester active (i_read, or d_read|d_write), the block SHALL capture that request into the address, data and op registers and enter SERVE_I or SERVE_D next cycle.
REQ-013 In IDLE with both requesters active, the block SHALL grant D (default arbitration; see REQ-025).
REQ-014 In SERVE_x, l2_read/l2_write/l2_address/l2_wdata SHALL be driven only from the captured registers; L1 inputs changing mid-transaction SHALL have no effect.
REQ-015 Latency: a request sampled in IDLE at edge N SHALL produce l2_read or l2_write high from edge N+1 onward.
REQ-016 In SERVE_x, the L2 op SHALL stay asserted until the cycle l2_resp=1; at that edge the FSM SHALL latch l2_rdata and enter DONE.
REQ-017 In DONE, exactly the granted requester's resp SHALL be high for one cycle; its rdata SHALL hold the latched line; l2_read/l2_write SHALL be low; the FSM SHALL return to IDLE next cycle.
REQ-018 A new request SHALL NOT be granted earlier than the cycle after DONE, so a requester still holding its read during DONE is not served twice.
REQ-019 If d_read and d_write are both high when sampled, the block SHALL treat the request as a write; d_rdata is then don't-care.
REQ-020 For a D write, d_resp SHALL still pulse in DONE; for an I request, l2_write SHALL never assert.
REQ-021 l2_resp in IDLE or DONE SHALL be ignored.
REQ-022 i_resp and d_resp SHALL never be high in the same cycle; l2_read and l2_write SHALL never be high in the same cycle.

Reset
REQ-023 On rst=1, without waiting for a clock edge, the FSM SHALL go to IDLE; all resp and l2 control outputs and busy SHALL be 0; captured address/data/rdata registers SHALL be 0.
REQ-024 A reset during SERVE_x SHALL abandon the L2 transaction: no resp is issued, and the first grant after reset SHALL follow REQ-012/013/025.

Configuration
REQ-025 With macro CACHE_ARB_ROUND_ROBIN_EN defined, a tie in IDLE SHALL grant the requester not granted last; the last-grant bit SHALL reset to D, so the first tie after reset grants I. Without the macro, a tie SHALL always grant D and no last-grant state SHALL exist.

Verification
REQ-026 Bench SHALL drive i_read=1, i_address=0x0000_0040 alone; L2 responds after 5 cycles with rdata=0xA5..A5 -> l2_read from cycle +1, i_resp one cycle with i_rdata=0xA5..A5, d_resp stays 0.
REQ-027 Bench SHALL drive d_write=1, d_address=0x1000_0020, d_wdata=0x3C..3C -> l2_write=1, l2_address=0x1000_0020, l2_wdata=0x3C..3C until l2_resp; then one d_resp pulse.
REQ-028 Bench SHALL assert i_read and d_read in the same cycle, without the macro -> D is served first, then I, each with one resp pulse. With the macro, after reset -> I first, then D, and a second tie -> D first.
REQ-029 Bench SHALL change d_address from 0x200 to 0x300 during SERVE_D -> l2_address stays 0x200 for the whole transaction.
REQ-030 Bench SHALL assert rst two cycles into SERVE_I -> l2_read, busy and i_resp drop immediately. With i_read held after reset -> a fresh transaction completes normally.
REQ-031 Bench SHALL keep i_read held high through DONE with a single request -> exactly one L2 transaction and one i_resp.
